// File: rtl/stream_checker_if.sv
// Message stream carrying a value from the read side of the queue into the checker.
//
// Handshake: a message transfers on a rising clk edge where in_val and in_rdy are
// both 1. The producer keeps in_val and in_msg steady until that edge. The consumer
// drives in_rdy from its own state only, never from in_val.
interface stream_checker_if #(
   parameter int p_data_width = 16
);
   logic                    in_val;
   logic                    in_rdy;
   logic [p_data_width-1:0] in_msg;

   modport master (output in_val, output in_msg, input  in_rdy);
   modport slave  (input  in_val, input  in_msg, output in_rdy);
endinterface

// File: rtl/stream_checker.sv
// stream_checker: consumes a val/rdy stream and checks it against the arithmetic
// sequence p_start, p_start+p_stride, ... (mod 2^p_data_width). It counts accepted
// messages and mismatches, and latches the first bad value. It ends in DONE after
// p_num_msgs messages, or in TIMEOUT after p_timeout consecutive idle cycles.
// Optional macro STREAM_CHECKER_STALL_EN adds LFSR-driven backpressure on in_rdy.
module stream_checker #(
   parameter int p_data_width = 16,
   parameter int p_num_msgs   = 4,
   parameter int p_start      = 10,
   parameter int p_stride     = 3,
   parameter int p_timeout    = 64,
   parameter int p_err_width  = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   stream_checker_if.slave                    s_in,
   output logic [$clog2(p_num_msgs+1)-1:0]    rcv_count,
   output logic [p_err_width-1:0]             err_count,
   output logic [p_data_width-1:0]            first_err_data,
   output logic                               done,
   output logic                               pass,
   output logic                               timeout,
   output logic [1:0]                         dbg_state
);

   localparam int c_rcv_w  = $clog2(p_num_msgs + 1);
   localparam int c_idle_w = $clog2(p_timeout + 1);
   localparam logic [p_data_width-1:0] c_start  = p_data_width'(p_start);
   localparam logic [p_data_width-1:0] c_stride = p_data_width'(p_stride);
   localparam logic [c_rcv_w-1:0]      c_last   = c_rcv_w'(p_num_msgs - 1);
   localparam logic [c_idle_w-1:0]     c_idle_max = c_idle_w'(p_timeout - 1);

   typedef enum logic [1:0] {
      ST_CHECK   = 2'd0,
      ST_DONE    = 2'd1,
      ST_TIMEOUT = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic [p_data_width-1:0] r_exp;
   logic [c_rcv_w-1:0]      r_rcv;
   logic [p_err_width-1:0]  r_err;
   logic [p_err_width-1:0]  w_err_next;
   logic [p_data_width-1:0] r_first;
   logic [c_idle_w-1:0]     r_idle;
   logic                    r_done;
   logic                    r_pass;
   logic                    r_timeout;
   logic                    w_slot;
   logic                    w_rdy;
   logic                    w_go;
   logic                    w_mismatch;
   logic                    w_idle_tick;

`ifdef STREAM_CHECKER_STALL_EN
   logic [7:0] r_lfsr;
   logic       w_lfsr_fb;

   // x^8+x^6+x^5+x^4+1 feedback; the sequence only moves while checking.
   assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

   // Backpressure generator: bit 0 opens the ready window.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lfsr <= 8'h01;
      end else if (r_state == ST_CHECK) begin
         r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
      end
   end

   assign w_slot = r_lfsr[0];
`else
   assign w_slot = 1'b1;
`endif

   // Ready depends on state (and stall slot) only; a transfer is val && rdy.
   assign w_rdy       = (r_state == ST_CHECK) && w_slot;
   assign w_go        = s_in.in_val && w_rdy;
   assign w_mismatch  = w_go && (s_in.in_msg != r_exp);
   // Stalled cycles neither count towards nor clear the idle run.
   assign w_idle_tick = (r_state == ST_CHECK) && w_slot && !w_go;

   // Saturating mismatch count as it will be after this edge.
   always_comb begin
      w_err_next = r_err;
      if (w_mismatch && !(&r_err)) begin
         w_err_next = r_err + 1'b1;
      end
   end

   // Next state: the final handshake beats a simultaneous idle expiry.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_CHECK: begin
            if (w_go && (r_rcv == c_last)) begin
               w_next_state = ST_DONE;
            end else if (w_idle_tick && (r_idle == c_idle_max)) begin
               w_next_state = ST_TIMEOUT;
            end
         end
         default: w_next_state = r_state;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_CHECK;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Counters, expected value and registered status flags; frozen outside CHECK.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_exp     <= c_start;
         r_rcv     <= '0;
         r_err     <= '0;
         r_first   <= '0;
         r_idle    <= '0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         if (w_go) begin
            r_exp  <= r_exp + c_stride;
            r_rcv  <= r_rcv + 1'b1;
            r_idle <= '0;
            r_err  <= w_err_next;
            if (w_mismatch && (r_err == '0)) begin
               r_first <= s_in.in_msg;
            end
         end else if (w_idle_tick) begin
            r_idle <= r_idle + 1'b1;
         end
         r_done    <= (w_next_state == ST_DONE);
         r_pass    <= (w_next_state == ST_DONE) && (w_err_next == '0);
         r_timeout <= (w_next_state == ST_TIMEOUT);
      end
   end

   assign s_in.in_rdy    = w_rdy;
   assign rcv_count      = r_rcv;
   assign err_count      = r_err;
   assign first_err_data = r_first;
   assign done           = r_done;
   assign pass           = r_pass;
   assign timeout        = r_timeout;
   assign dbg_state      = r_state;

endmodule
